// File: rtl/fs_request_arbiter_if.sv
// fs_request_arbiter_if: two requester ports plus the filesystem strobe/operand port
interface fs_request_arbiter_if;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_filename, req1_filename;
    logic [31:0] req0_address, req1_address;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        req0_done, req1_done;
    logic [31:0] req0_rdata, req1_rdata;
    logic        busy;
    logic        fs_rden, fs_wren, fs_del;
    logic [31:0] fs_filename, fs_address, fs_data, fs_q;

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_filename, req1_filename,
               req0_address, req1_address, req0_data, req1_data, fs_q,
        input  req0_ready, req1_ready, req0_done, req1_done, req0_rdata, req1_rdata, busy,
               fs_rden, fs_wren, fs_del, fs_filename, fs_address, fs_data
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_filename, req1_filename,
               req0_address, req1_address, req0_data, req1_data, fs_q,
        output req0_ready, req1_ready, req0_done, req1_done, req0_rdata, req1_rdata, busy,
               fs_rden, fs_wren, fs_del, fs_filename, fs_address, fs_data
    );
endinterface

// File: rtl/fs_request_arbiter.sv
// fs_request_arbiter: round-robin sharing of the ack-less filesystem port between two requesters,
// each op is a fixed strobe window followed by a recovery gap
module fs_request_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input logic CLOCK_50,
    input logic reset,
    fs_request_arbiter_if.slave bus
);
    localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    op, sel_op;
    logic          gnt, last_grant, grant, accept;
    logic [31:0]   sel_filename, sel_address, sel_data;

    always_comb begin
        grant          = (bus.req0_valid && bus.req1_valid) ? !last_grant : bus.req1_valid;
        bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
        bus.req1_ready = (state == IDLE) && bus.req1_valid && grant;
        accept         = bus.req0_ready || bus.req1_ready;
        sel_op         = grant ? bus.req1_op : bus.req0_op;
        sel_filename   = grant ? bus.req1_filename : bus.req0_filename;
        sel_address    = grant ? bus.req1_address : bus.req0_address;
        sel_data       = grant ? bus.req1_data : bus.req0_data;
        bus.busy       = state != IDLE;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            op              <= '0;
            gnt             <= 1'b0;
            last_grant      <= 1'b1;
            bus.fs_rden     <= 1'b0;
            bus.fs_wren     <= 1'b0;
            bus.fs_del      <= 1'b0;
            bus.fs_filename <= '0;
            bus.fs_address  <= '0;
            bus.fs_data     <= '0;
            bus.req0_rdata  <= '0;
            bus.req1_rdata  <= '0;
            bus.req0_done   <= 1'b0;
            bus.req1_done   <= 1'b0;
        end else begin
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    gnt             <= grant;
                    last_grant      <= grant;
                    op              <= sel_op;
                    bus.fs_filename <= sel_filename;
                    bus.fs_address  <= sel_address;
                    bus.fs_data     <= sel_data;
                    bus.fs_rden     <= sel_op == 2'b00;
                    bus.fs_wren     <= sel_op == 2'b01;
                    bus.fs_del      <= sel_op == 2'b10;
                    cnt             <= CW'(HOLD_CYCLES);
                    state           <= sel_op == 2'b11 ? DONE : ISSUE;
                    // a no-op completes immediately without touching the filesystem
                    bus.req0_done   <= sel_op == 2'b11 && !grant;
                    bus.req1_done   <= sel_op == 2'b11 && grant;
                end
                ISSUE: if (cnt == CW'(1)) begin
                    bus.fs_rden <= 1'b0;
                    bus.fs_wren <= 1'b0;
                    bus.fs_del  <= 1'b0;
                    cnt         <= CW'(GAP_CYCLES);
                    state       <= GAP;
                    if (op == 2'b00 && !gnt) bus.req0_rdata <= bus.fs_q;
                    if (op == 2'b00 && gnt) bus.req1_rdata <= bus.fs_q;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                GAP: if (cnt == CW'(1)) begin
                    state         <= DONE;
                    bus.req0_done <= !gnt;
                    bus.req1_done <= gnt;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fs_request_arbiter.sv
// tb_fs_request_arbiter: scenario tasks plus randomized ops checked against a transaction-level model
module tb_fs_request_arbiter;
    localparam int H = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          tests = 0;
    int          failed = 0;
    int          pend = 0;
    logic        m_last = 1'b1;
    logic [31:0] m_rdata [2];

    fs_request_arbiter_if bus();

    fs_request_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus)
    );

    always #10 clk = ~clk;

    task automatic set_req(input int n, input logic v, input logic [1:0] op,
                           input logic [31:0] fn, input logic [31:0] addr, input logic [31:0] data);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_filename = fn;
            bus.req0_address = addr; bus.req0_data = data;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_filename = fn;
            bus.req1_address = addr; bus.req1_data = data;
        end
    endtask

    function automatic logic ready_of(input int n);
        return n != 0 ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic valid_of(input int n);
        return n != 0 ? bus.req1_valid : bus.req0_valid;
    endfunction

    function automatic logic done_of(input int n);
        return n != 0 ? bus.req1_done : bus.req0_done;
    endfunction

    function automatic logic [31:0] rdata_of(input int n);
        return n != 0 ? bus.req1_rdata : bus.req0_rdata;
    endfunction

    // Invariants: strobes mutually exclusive, no ready while busy, at most one outstanding done
    always @(posedge clk) begin
        if (reset) pend <= 0;
        else pend <= pend + int'((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                          - int'(bus.req0_done) - int'(bus.req1_done);
    end

    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (int'(bus.fs_rden) + int'(bus.fs_wren) + int'(bus.fs_del) > 1) begin
                failed++;
                $display("FAIL strobe_onehot got rden=%b wren=%b del=%b want at most one",
                         bus.fs_rden, bus.fs_wren, bus.fs_del);
            end
            tests++;
            if (bus.busy && (bus.req0_ready || bus.req1_ready)) begin
                failed++;
                $display("FAIL ready_while_busy got ready0=%b ready1=%b want 0", bus.req0_ready, bus.req1_ready);
            end
            tests++;
            if (pend < 0 || pend > 1) begin
                failed++;
                $display("FAIL done_per_accept got outstanding=%0d want 0..1", pend);
            end
        end
    end

    // Issues one op from requester n (must be idle) and checks its whole timeline against the rules
    task automatic test_op(input int n, input logic [1:0] op, input logic [31:0] fn,
                           input logic [31:0] addr, input logic [31:0] data, input logic [31:0] q);
        int win, len;
        logic [2:0] strobes;
        win = valid_of(1 - n) ? 1 - int'(m_last) : n;
        set_req(n, 1'b1, op, fn, addr, data);
        bus.fs_q = q;
        #1;
        tests++;
        if (ready_of(n) !== (win == n)) begin
            failed++;
            $display("FAIL arb_ready%0d got %b want %b", n, ready_of(n), win == n);
        end
        tests++;
        if (ready_of(1 - n) !== 1'b0) begin
            failed++;
            $display("FAIL arb_other_ready%0d got %b want 0", 1 - n, ready_of(1 - n));
        end
        m_last = n[0];
        if (op == 2'b00) m_rdata[n] = q;
        len = (op == 2'b11) ? 1 : H + G + 1;
        @(posedge clk); #1;
        set_req(n, 1'b0, 2'($urandom), $urandom, $urandom, $urandom);
        for (int c = 1; c <= len; c++) begin
            strobes = (op != 2'b11 && c <= H) ? 3'b001 << op : 3'b000;
            if (c == H + 1) bus.fs_q = ~q;
            tests++;
            if ({bus.fs_del, bus.fs_wren, bus.fs_rden} !== strobes) begin
                failed++;
                $display("FAIL strobes c=%0d op=%0d got %b want %b", c, op,
                         {bus.fs_del, bus.fs_wren, bus.fs_rden}, strobes);
            end
            tests++;
            if ({bus.fs_filename, bus.fs_address, bus.fs_data} !== {fn, addr, data}) begin
                failed++;
                $display("FAIL operands c=%0d got %h/%h/%h want %h/%h/%h", c,
                         bus.fs_filename, bus.fs_address, bus.fs_data, fn, addr, data);
            end
            tests++;
            if (bus.busy !== 1'b1) begin
                failed++;
                $display("FAIL busy c=%0d got %b want 1", c, bus.busy);
            end
            tests++;
            if (done_of(n) !== (c == len) || done_of(1 - n) !== 1'b0) begin
                failed++;
                $display("FAIL done c=%0d req%0d got %b/%b want %b/0", c, n, done_of(n), done_of(1 - n), c == len);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (bus.busy !== 1'b0 || done_of(n) !== 1'b0) begin
            failed++;
            $display("FAIL idle_after got busy=%b done=%b want 0/0", bus.busy, done_of(n));
        end
        tests++;
        if (rdata_of(n) !== m_rdata[n] || rdata_of(1 - n) !== m_rdata[1 - n]) begin
            failed++;
            $display("FAIL rdata req%0d got %h/%h want %h/%h", n, rdata_of(n), rdata_of(1 - n),
                     m_rdata[n], m_rdata[1 - n]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        bus.fs_q = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({bus.fs_del, bus.fs_wren, bus.fs_rden, bus.busy, bus.req0_done, bus.req1_done} !== 6'b0) begin
            failed++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {bus.fs_del, bus.fs_wren, bus.fs_rden, bus.busy, bus.req0_done, bus.req1_done});
        end
        tests++;
        if ({bus.fs_filename, bus.fs_address, bus.fs_data, bus.req0_rdata, bus.req1_rdata} !== 160'h0) begin
            failed++;
            $display("FAIL reset_data got %h/%h/%h/%h/%h want 0", bus.fs_filename, bus.fs_address,
                     bus.fs_data, bus.req0_rdata, bus.req1_rdata);
        end
        reset = 1'b0;
        m_last = 1'b1;
        m_rdata[0] = 32'h0;
        m_rdata[1] = 32'h0;
    endtask

    task automatic test_contention();
        set_req(1, 1'b1, 2'b01, 32'hF1, 32'h20, 32'hCAFE0001);
        test_op(0, 2'b00, 32'hF0, 32'h10, 32'h0, 32'hDEADBEEF);
        test_op(1, 2'b01, 32'hF1, 32'h20, 32'hCAFE0001, 32'h0);
        set_req(1, 1'b1, 2'b10, 32'hF3, 32'h30, 32'h0);
        test_op(0, 2'b00, 32'hF2, 32'h11, 32'h0, 32'h0BADF00D);
        test_op(1, 2'b10, 32'hF3, 32'h30, 32'h0, 32'h0);
    endtask

    task automatic test_write();
        test_op(1, 2'b01, 32'hA5, 32'h44, 32'h12345678, 32'h99999999);
    endtask

    task automatic test_delete_noop();
        test_op(0, 2'b10, 32'hD1, 32'h0, 32'h0, 32'h11111111);
        test_op(0, 2'b11, 32'hD2, 32'h1, 32'h2, 32'h22222222);
        test_op(1, 2'b11, 32'hD3, 32'h3, 32'h4, 32'h33333333);
    endtask

    task automatic test_reset_midop();
        test_op(0, 2'b00, 32'hE0, 32'h5, 32'h0, 32'h5555AAAA);
        set_req(0, 1'b1, 2'b00, 32'hE1, 32'h6, 32'h0);
        bus.fs_q = 32'h77777777;
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'b00, 32'hE1, 32'h6, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (bus.fs_rden !== 1'b1) begin
            failed++;
            $display("FAIL midop_rden got %b want 1", bus.fs_rden);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1'b1;
        m_rdata[0] = 32'h0;
        m_rdata[1] = 32'h0;
        tests++;
        if ({bus.fs_del, bus.fs_wren, bus.fs_rden, bus.busy, bus.req0_done} !== 5'b0 || bus.req0_rdata !== 32'h0) begin
            failed++;
            $display("FAIL midop_reset got ctrl=%b rdata0=%h want 00000/0",
                     {bus.fs_del, bus.fs_wren, bus.fs_rden, bus.busy, bus.req0_done}, bus.req0_rdata);
        end
        for (int c = 0; c < H + G + 2; c++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.req0_done !== 1'b0 || bus.busy !== 1'b0) begin
                failed++;
                $display("FAIL aborted_op c=%0d got done=%b busy=%b want 0/0", c, bus.req0_done, bus.busy);
            end
        end
        test_op(0, 2'b00, 32'hE2, 32'h7, 32'h0, 32'h600DCAFE);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int n;
            logic both;
            both = 1'($urandom_range(0, 1));
            n = both ? 1 - int'(m_last) : int'($urandom_range(0, 1));
            if (both) set_req(1 - n, 1'b1, 2'($urandom), $urandom, $urandom, $urandom);
            test_op(n, 2'($urandom), $urandom, $urandom, $urandom, $urandom);
            set_req(1 - n, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write();
        test_delete_noop();
        test_reset_midop();
        test_random();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
